// File: rtl/blood_sprite_reader.sv
// ============================================================================
// Module   : blood_sprite_reader
// Purpose  : Blood-splatter sprite reader. Maps scan position to ROM row/col, aligns the
//            registered ROM read, keys out transparency and runs the hit animation.
//            Optional BLOOD_FADE_EN halves each colour channel on the last frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module blood_sprite_reader #(
    parameter int          N_FRAMES    = 8,
    parameter int          FRAME_TICKS = 4,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [9:0]                  video_x,
    input  logic [9:0]                  video_y,
    input  logic                        video_on,
    input  logic                        frame_tick,
    input  logic                        trigger,
    input  logic [9:0]                  anchor_x,
    input  logic [9:0]                  anchor_y,
    output logic [5:0]                  rom_row,
    output logic [5:0]                  rom_col,
    output logic [$clog2(N_FRAMES)-1:0] rom_frame,
    input  logic [11:0]                 rom_color,
    output logic                        busy,
    output logic                        done,
    output logic                        pix_on,
    output logic [11:0]                 pix_rgb
);

    localparam int                FW           = $clog2(N_FRAMES);
    localparam logic [FW-1:0]     c_last_frame = FW'(N_FRAMES - 1);
    localparam logic [7:0]        c_last_tick  = 8'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [FW-1:0]   r_frame, w_frame_nx;
    logic [7:0]      r_tick,  w_tick_nx;
    logic [9:0]      r_ax, w_ax_nx;
    logic [9:0]      r_ay, w_ay_nx;
    logic            r_vis;
    logic            r_pix_on;
    logic [11:0]     r_pix_rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_frame <= '0;
            r_tick  <= '0;
            r_ax    <= '0;
            r_ay    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_frame <= w_frame_nx;
            r_tick  <= w_tick_nx;
            r_ax    <= w_ax_nx;
            r_ay    <= w_ay_nx;
        end
    end

    // A trigger restarts from any state and overrides a coincident final tick.
    always_comb begin
        w_state_nx = r_state;
        w_frame_nx = r_frame;
        w_tick_nx  = r_tick;
        w_ax_nx    = r_ax;
        w_ay_nx    = r_ay;
        if (trigger) begin
            w_state_nx = S_PLAY;
            w_frame_nx = '0;
            w_tick_nx  = '0;
            w_ax_nx    = anchor_x;
            w_ay_nx    = anchor_y;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (frame_tick) begin
                        if (r_tick == c_last_tick) begin
                            w_tick_nx = '0;
                            if (r_frame == c_last_frame) begin
                                w_state_nx = S_DONE;
                            end else begin
                                w_frame_nx = r_frame + 1'b1;
                            end
                        end else begin
                            w_tick_nx = r_tick + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nx = S_IDLE;
                    w_frame_nx = '0;
                end
                default: begin
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    // Unsigned 10-bit wrap makes positions left/above the anchor fall outside the box.
    logic [9:0] w_dx, w_dy;
    logic       w_in_box;
    logic       w_opaque;
    logic [11:0] w_color;

    assign w_dx     = video_x - r_ax;
    assign w_dy     = video_y - r_ay;
    assign w_in_box = (w_dx < 10'd64) && (w_dy < 10'd64);
    assign rom_col  = w_dx[5:0];
    assign rom_row  = w_dy[5:0];
    assign w_opaque = (rom_color != TRANSPARENT);

`ifdef BLOOD_FADE_EN
    assign w_color = (r_frame == c_last_frame)
                   ? {1'b0, rom_color[11:9], 1'b0, rom_color[7:5], 1'b0, rom_color[3:1]}
                   : rom_color;
`else
    assign w_color = rom_color;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vis     <= 1'b0;
            r_pix_on  <= 1'b0;
            r_pix_rgb <= '0;
        end else begin
            r_vis     <= w_in_box & video_on & (r_state == S_PLAY);
            r_pix_on  <= r_vis & w_opaque;
            r_pix_rgb <= (r_vis & w_opaque) ? w_color : 12'h000;
        end
    end

    assign rom_frame = r_frame;
    assign busy      = (r_state == S_PLAY);
    assign done      = (r_state == S_DONE);
    assign pix_on    = r_pix_on;
    assign pix_rgb   = r_pix_rgb;

endmodule

`default_nettype wire

// File: tb/tb_blood_sprite_reader.sv
// ============================================================================
// Module   : tb_blood_sprite_reader
// Purpose  : Directed self-checking bench for blood_sprite_reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blood_sprite_reader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  video_x = '0, video_y = '0;
    logic        video_on = 1'b0;
    logic        frame_tick = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  anchor_x = '0, anchor_y = '0;
    logic [5:0]  rom_row, rom_col;
    logic [2:0]  rom_frame;
    logic [11:0] rom_color = '0;
    logic        busy, done, pix_on;
    logic [11:0] pix_rgb;

    int vectors = 0;
    int miscompares = 0;

    blood_sprite_reader dut (
        .clk(clk), .reset_n(reset_n),
        .video_x(video_x), .video_y(video_y), .video_on(video_on),
        .frame_tick(frame_tick), .trigger(trigger),
        .anchor_x(anchor_x), .anchor_y(anchor_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_frame(rom_frame),
        .rom_color(rom_color),
        .busy(busy), .done(done), .pix_on(pix_on), .pix_rgb(pix_rgb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_trigger(input logic [9:0] ax, input logic [9:0] ay);
        anchor_x = ax;
        anchor_y = ay;
        trigger  = 1'b1;
        step();
        trigger  = 1'b0;
    endtask

    // Presents a scan position, feeds ROM data one cycle later, returns registered pixel.
    task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [11:0] col,
                         output logic on, output logic [11:0] rgb);
        video_x  = x;
        video_y  = y;
        video_on = 1'b1;
        step();
        video_on  = 1'b0;
        rom_color = col;
        step();
        on  = pix_on;
        rgb = pix_rgb;
    endtask

    task automatic test_reset();
        logic on;
        logic [11:0] rgb;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || pix_on !== 1'b0 || pix_rgb !== 12'h000 || rom_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b pix_on=%b pix_rgb=%h frame=%0d, want all 0", busy, done, pix_on, pix_rgb, rom_frame);
        end
        for (int i = 0; i < 4; i++) begin
            probe(10'(i * 20), 10'(i * 15), 12'hF00, on, rgb);
            vectors++;
            if (on !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_scan[%0d]: pix_on=%b busy=%b, want 0 0", i, on, busy);
            end
        end
    endtask

    task automatic test_animation();
        int done_cnt = 0;
        do_trigger(10'd100, 10'd50);
        vectors++;
        if (busy !== 1'b1 || rom_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL anim_start: busy=%b frame=%0d, want 1 0", busy, rom_frame);
        end
        for (int k = 1; k <= 32; k++) begin
            pulse_tick();
            if (done === 1'b1) done_cnt++;
            if (k < 32) begin
                vectors++;
                if (rom_frame !== 3'(k / 4) || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL anim_tick%0d: frame=%0d busy=%b, want %0d 1", k, rom_frame, busy, k / 4);
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL anim_done: done=%b busy=%b, want 1 0", done, busy);
        end
        step();
        if (done === 1'b1) done_cnt++;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || rom_frame !== 3'd0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL anim_idle: done=%b busy=%b frame=%0d pulses=%0d, want 0 0 0 1", done, busy, rom_frame, done_cnt);
        end
    endtask

    task automatic test_addressing();
        logic on;
        logic [11:0] rgb;
        do_trigger(10'd100, 10'd50);
        video_x = 10'd163;
        video_y = 10'd113;
        #1;
        vectors++;
        if (rom_col !== 6'd63 || rom_row !== 6'd63) begin
            miscompares++;
            $display("FAIL addr_corner: col=%0d row=%0d, want 63 63", rom_col, rom_row);
        end
        probe(10'd163, 10'd113, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b1 || rgb !== 12'hF00) begin
            miscompares++;
            $display("FAIL pix_corner: pix_on=%b rgb=%h, want 1 f00", on, rgb);
        end
        probe(10'd164, 10'd113, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b0 || rgb !== 12'h000) begin
            miscompares++;
            $display("FAIL pix_right_edge: pix_on=%b rgb=%h, want 0 000", on, rgb);
        end
        probe(10'd99, 10'd50, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b0) begin
            miscompares++;
            $display("FAIL pix_left_wrap: pix_on=%b, want 0", on);
        end
        probe(10'd100, 10'd50, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b1 || rgb !== 12'hF00) begin
            miscompares++;
            $display("FAIL pix_origin: pix_on=%b rgb=%h, want 1 f00", on, rgb);
        end
    endtask

    task automatic test_transparency();
        logic on;
        logic [11:0] rgb;
        logic [11:0] exp_fade;
        probe(10'd120, 10'd60, 12'h000, on, rgb);
        vectors++;
        if (on !== 1'b0 || rgb !== 12'h000) begin
            miscompares++;
            $display("FAIL transparent: pix_on=%b rgb=%h, want 0 000", on, rgb);
        end
        probe(10'd120, 10'd60, 12'hE00, on, rgb);
        vectors++;
        if (on !== 1'b1 || rgb !== 12'hE00) begin
            miscompares++;
            $display("FAIL opaque_e00: pix_on=%b rgb=%h, want 1 e00", on, rgb);
        end
        do_trigger(10'd100, 10'd50);
        for (int k = 0; k < 28; k++) pulse_tick();
`ifdef BLOOD_FADE_EN
        exp_fade = 12'h700;
`else
        exp_fade = 12'hE00;
`endif
        probe(10'd120, 10'd60, 12'hE00, on, rgb);
        vectors++;
        if (rom_frame !== 3'd7 || on !== 1'b1 || rgb !== exp_fade) begin
            miscompares++;
            $display("FAIL last_frame_rgb: frame=%0d pix_on=%b rgb=%h, want 7 1 %h", rom_frame, on, rgb, exp_fade);
        end
    endtask

    task automatic test_retrigger();
        logic on;
        logic [11:0] rgb;
        do_trigger(10'd100, 10'd50);
        for (int k = 0; k < 22; k++) pulse_tick();
        do_trigger(10'd300, 10'd200);
        vectors++;
        if (rom_frame !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL retrig: frame=%0d busy=%b done=%b, want 0 1 0", rom_frame, busy, done);
        end
        for (int k = 0; k < 3; k++) pulse_tick();
        vectors++;
        if (rom_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL retrig_tick_clear: frame=%0d after 3 ticks, want 0", rom_frame);
        end
        pulse_tick();
        vectors++;
        if (rom_frame !== 3'd1) begin
            miscompares++;
            $display("FAIL retrig_tick4: frame=%0d, want 1", rom_frame);
        end
        probe(10'd163, 10'd113, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b0) begin
            miscompares++;
            $display("FAIL retrig_old_box: pix_on=%b, want 0", on);
        end
        probe(10'd300, 10'd200, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b1 || rgb !== 12'hF00) begin
            miscompares++;
            $display("FAIL retrig_new_box: pix_on=%b rgb=%h, want 1 f00", on, rgb);
        end
    endtask

    task automatic test_trigger_wins();
        do_trigger(10'd100, 10'd50);
        for (int k = 0; k < 31; k++) pulse_tick();
        frame_tick = 1'b1;
        do_trigger(10'd10, 10'd10);
        frame_tick = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1 || rom_frame !== 3'd0) begin
            miscompares++;
            $display("FAIL trigger_wins: done=%b busy=%b frame=%0d, want 0 1 0", done, busy, rom_frame);
        end
        step();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL trigger_wins_next: done=%b busy=%b, want 0 1", done, busy);
        end
    endtask

    task automatic test_async_reset_and_wrap();
        logic on;
        logic [11:0] rgb;
        do_trigger(10'd100, 10'd50);
        for (int k = 0; k < 9; k++) pulse_tick();
        probe(10'd110, 10'd60, 12'hF00, on, rgb);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || pix_on !== 1'b0 || pix_rgb !== 12'h000 || rom_frame !== 3'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b pix_on=%b rgb=%h frame=%0d done=%b, want all 0", busy, pix_on, pix_rgb, rom_frame, done);
        end
        step();
        reset_n = 1'b1;
        step();
        do_trigger(10'd620, 10'd0);
        probe(10'd619, 10'd5, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_619: pix_on=%b, want 0", on);
        end
        probe(10'd0, 10'd5, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_0: pix_on=%b, want 0", on);
        end
        probe(10'd620, 10'd5, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_620: pix_on=%b, want 1", on);
        end
        video_x = 10'd639;
        #1;
        vectors++;
        if (rom_col !== 6'd19) begin
            miscompares++;
            $display("FAIL wrap_col639: col=%0d, want 19", rom_col);
        end
        probe(10'd639, 10'd5, 12'hF00, on, rgb);
        vectors++;
        if (on !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_639: pix_on=%b, want 1", on);
        end
    endtask

    initial begin
        step();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_reset();
        test_animation();
        test_addressing();
        test_transparency();
        test_retrigger();
        test_trigger_wins();
        test_async_reset_and_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
